// File: rtl/tube_bcd_conv_pkg.sv
// rtl/tube_bcd_conv_pkg.sv - shared widths, codes and nibble helper for the tube display-data stage
package tube_bcd_conv_pkg;

  localparam int          DATABUS   = 32;
  localparam int          MODE_BIT  = 16;
  localparam logic [15:0] OVF_CODE  = 16'hEEEE;
  localparam logic [15:0] DEC_LIMIT = 16'd9999;

  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/tube_bcd_conv_bcd_dabble_step.sv
// rtl/tube_bcd_conv_bcd_dabble_step.sv - one combinational double-dabble iteration
module bcd_dabble_step
  import tube_bcd_conv_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  logic [31:0] adj;

  assign adj  = {add3(din[31:28]), add3(din[27:24]), add3(din[23:20]), add3(din[19:16]), din[15:0]};
  // Top bit is always zero for inputs that passed the range check.
  assign dout = {adj[30:0], 1'b0};

endmodule

// File: rtl/tube_bcd_conv.sv
// rtl/tube_bcd_conv.sv - CPU write to tube display word, hex passthrough or sequential BCD conversion
module tube_bcd_conv
  import tube_bcd_conv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [DATABUS-1:0] wdata,
  output logic [15:0]        disp_data,
  output logic               busy,
  output logic               done,
  output logic               pend
);

  localparam int CONV_CYCLES = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [4:0]        cnt;
  logic [31:0]       sreg;
  logic [31:0]       step_out;
  logic [15:0]       result;
  logic [MODE_BIT:0] pbuf;
  logic [MODE_BIT:0] src;
  logic              src_valid;
  logic              unused_bits;

  assign unused_bits = ^wdata[DATABUS-1:MODE_BIT+1];

  // A live write always wins over the buffered one.
  assign src_valid = we | pend;
  assign src       = we ? wdata[MODE_BIT:0] : pbuf;
  assign busy      = (state != S_IDLE);

  bcd_dabble_step u_step (
    .din  (sreg),
    .dout (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 5'd0;
      sreg      <= 32'd0;
      result    <= 16'd0;
      disp_data <= 16'd0;
      done      <= 1'b0;
      pend      <= 1'b0;
      pbuf      <= '0;
    end else begin
      done <= 1'b0;

      if (we && state != S_IDLE) begin
        pbuf <= wdata[MODE_BIT:0];
        pend <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (src_valid) begin
            if (!we) pend <= 1'b0;
            if (!src[MODE_BIT]) begin
              result <= src[15:0];
              state  <= S_DONE;
            end else if (src[15:0] > DEC_LIMIT) begin
              result <= OVF_CODE;
              state  <= S_DONE;
            end else begin
              sreg  <= {16'd0, src[15:0]};
              cnt   <= 5'd0;
              state <= S_CONV;
            end
          end
        end
        S_CONV: begin
          sreg <= step_out;
          cnt  <= cnt + 5'd1;
          if (cnt == 5'(CONV_CYCLES - 1)) begin
            result <= step_out[31:16];
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          disp_data <= result;
          done      <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tube_bcd_conv.sv
// tb/tb_tube_bcd_conv.sv - directed self-checking bench for tube_bcd_conv
module tb_tube_bcd_conv;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [15:0] disp_data;
  logic        busy;
  logic        done;
  logic        pend;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tube_bcd_conv dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wdata     (wdata),
    .disp_data (disp_data),
    .busy      (busy),
    .done      (done),
    .pend      (pend)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] d);
    we = 1'b1;
    wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    while (!done && edges < limit) begin
      cyc();
      edges++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    chk("reset_disp", {16'd0, disp_data}, 32'h0000);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_pend", {31'd0, pend}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("hold_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_hex();
    int e;
    do_write(32'h0000_BEEF);
    chk("hex_busy_e0", {31'd0, busy}, 32'd1);
    chk("hex_done_e0", {31'd0, done}, 32'd0);
    wait_done(40, e);
    chk("hex_latency", e + 1, 2);
    chk("hex_disp", {16'd0, disp_data}, 32'hBEEF);
    chk("hex_busy_e1", {31'd0, busy}, 32'd0);
    cyc();
    chk("hex_done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic run_job(input string name, input logic [31:0] d, input logic [15:0] exp_disp,
                         input int exp_lat);
    int e;
    int busy_low;
    do_write(d);
    busy_low = 0;
    e = 0;
    while (!done && e < 40) begin
      if (!busy) busy_low++;
      cyc();
      e++;
    end
    chk({name, "_latency"}, e + 1, exp_lat);
    chk({name, "_disp"}, {16'd0, disp_data}, {16'd0, exp_disp});
    chk({name, "_busy_held"}, busy_low, 0);
    cyc();
  endtask

  task automatic test_decimal();
    run_job("dec1234", 32'h0001_04D2, 16'h1234, 18);
    run_job("dec9999", 32'h0001_270F, 16'h9999, 18);
    run_job("dec0", 32'h0001_0000, 16'h0000, 18);
    run_job("upper_ignored", 32'hFFFE_0063, 16'h0063, 2);
  endtask

  task automatic test_overflow();
    run_job("ovf10000", 32'h0001_2710, 16'hEEEE, 2);
    run_job("ovfmax", 32'h0001_FFFF, 16'hEEEE, 2);
  endtask

  task automatic test_back_to_back();
    int e;
    int saw_aa;
    do_write(32'h0001_002A);
    cyc();
    do_write(32'h0000_00AA);
    do_write(32'h0000_00BB);
    chk("b2b_pend", {31'd0, pend}, 32'd1);
    saw_aa = 0;
    e = 3;
    while (!done && e < 40) begin
      cyc();
      e++;
    end
    chk("b2b_first_latency", e + 1, 18);
    chk("b2b_first_disp", {16'd0, disp_data}, 32'h0042);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_pend", {31'd0, pend}, 32'd1);
    cyc();
    chk("b2b_capture_busy", {31'd0, busy}, 32'd1);
    chk("b2b_capture_pend", {31'd0, pend}, 32'd0);
    chk("b2b_capture_done", {31'd0, done}, 32'd0);
    cyc();
    chk("b2b_second_done", {31'd0, done}, 32'd1);
    chk("b2b_second_disp", {16'd0, disp_data}, 32'h00BB);
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (done && disp_data == 16'h00AA) saw_aa++;
    end
    chk("b2b_aa_dropped", saw_aa, 0);
  endtask

  task automatic test_done_write();
    int e;
    do_write(32'h0000_0011);
    do_write(32'h0000_0022);
    chk("dw_first_done", {31'd0, done}, 32'd1);
    chk("dw_first_disp", {16'd0, disp_data}, 32'h0011);
    chk("dw_pend", {31'd0, pend}, 32'd1);
    cyc();
    chk("dw_capture_busy", {31'd0, busy}, 32'd1);
    chk("dw_capture_pend", {31'd0, pend}, 32'd0);
    cyc();
    chk("dw_second_done", {31'd0, done}, 32'd1);
    chk("dw_second_disp", {16'd0, disp_data}, 32'h0022);
    cyc();
    do_write(32'h0001_0005);
    do_write(32'h0000_0033);
    wait_done(40, e);
    chk("pri_dec_disp", {16'd0, disp_data}, 32'h0005);
    chk("pri_pend_set", {31'd0, pend}, 32'd1);
    do_write(32'h0000_0044);
    chk("pri_direct_busy", {31'd0, busy}, 32'd1);
    chk("pri_pend_kept", {31'd0, pend}, 32'd1);
    cyc();
    chk("pri_direct_disp", {16'd0, disp_data}, 32'h0044);
    chk("pri_direct_done", {31'd0, done}, 32'd1);
    cyc();
    chk("pri_buf_busy", {31'd0, busy}, 32'd1);
    chk("pri_buf_pend", {31'd0, pend}, 32'd0);
    cyc();
    chk("pri_buf_disp", {16'd0, disp_data}, 32'h0033);
    cyc();
  endtask

  task automatic test_reset_mid();
    do_write(32'h0001_04D2);
    cyc();
    do_write(32'h0000_0077);
    cyc();
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    chk("mid_pend_pre", {31'd0, pend}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_disp", {16'd0, disp_data}, 32'h0000);
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_pend", {31'd0, pend}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_disp", {16'd0, disp_data}, 32'h0000);
  endtask

  initial begin
    #1;
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_back_to_back();
    test_done_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
